fifo_uart_tx: RTL and testbench

Read-side drain engine for the 8-entry byte FIFO. It pops bytes from the FIFO and serialises each one as an asynchronous UART frame on a single line: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits. It sits between the FIFO's read port (rd_en / data_out / empty) and the board-level TX pin, and is the transmit counterpart to the FIFO write path.

---
 rtl/fifo_uart_tx_if.sv | 33 +++
 rtl/fifo_uart_tx.sv | 201 ++++++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_uart_tx_if.sv
// ---------------------------------------------------------------------------
// fifo_uart_tx_if
// Read-port bundle between the 8-entry byte FIFO and its UART drain engine.
//
//   fifo_empty  FIFO -> engine   FIFO empty flag
//   fifo_wr_en  FIFO -> engine   copy of the FIFO write enable (a write cycle
//                                blocks the pop, the FIFO ignores rd_en then)
//   fifo_data   FIFO -> engine   registered data_out, valid the cycle after an
//                                accepted rd_en
//   fifo_rd_en  engine -> FIFO   pop request
//
// master: the drain engine. slave: the FIFO read side.
// ---------------------------------------------------------------------------
interface fifo_uart_tx_if;
    logic       fifo_empty;
    logic       fifo_wr_en;
    logic [7:0] fifo_data;
    logic       fifo_rd_en;

    modport master (
        input  fifo_empty,
        input  fifo_wr_en,
        input  fifo_data,
        output fifo_rd_en
    );

    modport slave (
        output fifo_empty,
        output fifo_wr_en,
        output fifo_data,
        input  fifo_rd_en
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// fifo_uart_tx
// Drains the byte FIFO and sends each byte as an asynchronous UART frame:
// start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Every bit lasts exactly CLKS_PER_BIT cycles.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per UART bit (2..65535)
//   PARITY        0 = none, 1 = even, 2 = odd
//   STOP_BITS     1 or 2
//
// Ports
//   i_clk         system clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_tx_en       allows new frames to start; a running frame always finishes
//   fifo_rd       FIFO read port (empty, wr_en copy, data_out, rd_en)
//   o_tx          serial line, idle high, registered
//   o_busy        high whenever the engine is not idle, registered
//   o_frame_done  one-cycle pulse on the last cycle of the final stop bit
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | line high; pops a byte when enabled and the FIFO has one
// FETCH  | one cycle; popped byte appears on fifo_data and is latched
// START  | line low for one bit time
// DATA   | eight data bits, LSB first, shifting out of r_shift
// PARITY | parity bit (only when PARITY != 0)
// STOP   | line high for STOP_BITS bit times, then back to IDLE
// ---------------------------------------------------------------------------
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_tx_en,
    fifo_uart_tx_if.master fifo_rd,
    output logic           o_tx,
    output logic           o_busy,
    output logic           o_frame_done
);

    localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       DATA_LAST = 3'd7;
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic             PAR_ODD   = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           r_state;
    logic             r_tx;
    logic             r_busy;
    logic [7:0]       r_shift;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic             r_parity;

    state_t           w_state_nxt;
    logic             w_tx_nxt;
    logic [7:0]       w_shift_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       w_bit_nxt;
    logic             w_parity_nxt;
    logic             w_bit_end;
    logic             w_rd_en;
    logic             w_parity_fold;

    // Reset gates the pop so a FIFO holding data is never drained while the
    // engine is held in reset. A write cycle defers the pop by one cycle.
    assign w_rd_en = i_rst_n && (r_state == S_IDLE) && i_tx_en &&
                     !fifo_rd.fifo_empty && !fifo_rd.fifo_wr_en;

    assign fifo_rd.fifo_rd_en = w_rd_en;

    assign w_bit_end     = (r_cnt == CNT_LAST);
    // Parity including the bit currently on the line.
    assign w_parity_fold = r_parity ^ r_shift[0];

    always_comb begin
        w_state_nxt  = r_state;
        w_tx_nxt     = 1'b1;
        w_shift_nxt  = r_shift;
        w_cnt_nxt    = r_cnt + CNT_W'(1);
        w_bit_nxt    = r_bit_idx;
        w_parity_nxt = r_parity;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                w_bit_nxt = '0;
                if (w_rd_en) begin
                    w_state_nxt = S_FETCH;
                end
            end

            S_FETCH: begin
                w_shift_nxt  = fifo_rd.fifo_data;
                w_parity_nxt = 1'b0;
                w_cnt_nxt    = '0;
                w_bit_nxt    = '0;
                w_state_nxt  = S_START;
                w_tx_nxt     = 1'b0;
            end

            S_START: begin
                w_tx_nxt = 1'b0;
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_DATA;
                    w_tx_nxt    = r_shift[0];
                end
            end

            S_DATA: begin
                w_tx_nxt = r_shift[0];
                if (w_bit_end) begin
                    w_cnt_nxt    = '0;
                    w_shift_nxt  = {1'b0, r_shift[7:1]};
                    w_parity_nxt = w_parity_fold;
                    if (r_bit_idx == DATA_LAST) begin
                        w_bit_nxt = '0;
                        if (PARITY != 0) begin
                            w_state_nxt = S_PARITY;
                            w_tx_nxt    = w_parity_fold ^ PAR_ODD;
                        end else begin
                            w_state_nxt = S_STOP;
                            w_tx_nxt    = 1'b1;
                        end
                    end else begin
                        w_bit_nxt = r_bit_idx + 3'd1;
                        // The next data bit is the one that lands in shift[0].
                        w_tx_nxt  = r_shift[1];
                    end
                end
            end

            S_PARITY: begin
                w_tx_nxt = r_parity ^ PAR_ODD;
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = S_STOP;
                    w_tx_nxt    = 1'b1;
                end
            end

            S_STOP: begin
                w_tx_nxt = 1'b1;
                if (w_bit_end) begin
                    w_cnt_nxt = '0;
                    if (r_bit_idx == STOP_LAST) begin
                        w_bit_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_bit_nxt = r_bit_idx + 3'd1;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_bit_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_shift   <= '0;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_parity  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_tx      <= w_tx_nxt;
            r_busy    <= (w_state_nxt != S_IDLE);
            r_shift   <= w_shift_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_nxt;
            r_parity  <= w_parity_nxt;
        end
    end

    assign o_tx         = r_tx;
    assign o_busy       = r_busy;
    assign o_frame_done = (r_state == S_STOP) && w_bit_end && (r_bit_idx == STOP_LAST);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_fifo_uart_tx
// Four engines (CLKS_PER_BIT=4) share one write stream:
//   0: no parity, 1 stop   1: even parity   2: odd parity   3: 2 stop bits
// Each has its own FIFO read pointer. The reference model turns each popped
// byte into the expected line waveform (one entry per clock) and checks tx,
// busy, frame_done, rd_en and FIFO occupancy every cycle at the falling edge.
// ---------------------------------------------------------------------------
module tb_fifo_uart_tx;

    localparam int CPB = 4;
    localparam int ND  = 4;

    logic       clk;
    logic       rst_n;
    logic       tx_en;
    logic       wr_en;
    logic [7:0] wr_data;

    logic       tx_o   [ND];
    logic       busy_o [ND];
    logic       fd_o   [ND];
    logic       rd_o   [ND];

    // FIFO environment (reacts to the DUTs' pop requests)
    logic [7:0] env_mem  [1024];
    int         env_wr = 0;
    int         env_rd   [ND] = '{0, 0, 0, 0};
    logic [7:0] env_data [ND] = '{8'h00, 8'h00, 8'h00, 8'h00};

    // Reference model state
    logic [7:0]  wlog [1024];
    int          wlog_n;
    int          m_ptr   [ND];
    logic [63:0] exp_tx  [ND];
    int          exp_len [ND];
    int          exp_pos [ND];

    int n_assert;
    int n_fail;
    int cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        fifo_uart_tx_if bus ();

        assign bus.fifo_empty = (env_wr == env_rd[g]);
        assign bus.fifo_wr_en = wr_en;
        assign bus.fifo_data  = env_data[g];
        assign rd_o[g]        = bus.fifo_rd_en;

        fifo_uart_tx #(
            .CLKS_PER_BIT (CPB),
            .PARITY       ((g == 1) ? 1 : (g == 2) ? 2 : 0),
            .STOP_BITS    ((g == 3) ? 2 : 1)
        ) dut (
            .i_clk        (clk),
            .i_rst_n      (rst_n),
            .i_tx_en      (tx_en),
            .fifo_rd      (bus.master),
            .o_tx         (tx_o[g]),
            .o_busy       (busy_o[g]),
            .o_frame_done (fd_o[g])
        );
    end

    always @(posedge clk) begin
        for (int k = 0; k < ND; k++) begin
            if (!wr_en && rd_o[k] && (env_wr != env_rd[k])) begin
                env_data[k] <= env_mem[env_rd[k]];
                env_rd[k]   <= env_rd[k] + 1;
            end
        end
        if (wr_en) begin
            env_mem[env_wr] <= wr_data;
            env_wr          <= env_wr + 1;
        end
    end

    function automatic int par_of(input int k);
        return (k == 1) ? 1 : (k == 2) ? 2 : 0;
    endfunction

    function automatic int stop_of(input int k);
        return (k == 3) ? 2 : 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Expected line per clock from the FETCH cycle to the last stop cycle.
    task automatic build_frame(input int k, input logic [7:0] b);
        logic [63:0] v;
        int          n;
        logic        p;
        v = '0;
        n = 0;
        v[n] = 1'b1; n++;
        repeat (CPB) begin v[n] = 1'b0; n++; end
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) begin v[n] = b[i]; n++; end
        end
        if (par_of(k) != 0) begin
            p = (^b) ^ (par_of(k) == 2);
            repeat (CPB) begin v[n] = p; n++; end
        end
        repeat (stop_of(k) * CPB) begin v[n] = 1'b1; n++; end
        exp_tx[k]  = v;
        exp_len[k] = n;
        exp_pos[k] = 0;
    endtask

    // Called at posedge+1 after inputs are set; checks at the falling edge,
    // predicts the coming edge, returns at the next posedge+1.
    task automatic step();
        logic e_tx, e_busy, e_fd, e_rd;
        @(negedge clk);
        for (int k = 0; k < ND; k++) begin
            if (!rst_n) begin
                e_tx = 1'b1; e_busy = 1'b0; e_fd = 1'b0; e_rd = 1'b0;
                exp_len[k] = 0;
                exp_pos[k] = 0;
            end else if (exp_len[k] != 0) begin
                e_tx   = exp_tx[k][exp_pos[k]];
                e_fd   = (exp_pos[k] == exp_len[k] - 1);
                e_busy = 1'b1;
                e_rd   = 1'b0;
                exp_pos[k]++;
                if (exp_pos[k] == exp_len[k]) exp_len[k] = 0;
            end else begin
                e_tx = 1'b1; e_busy = 1'b0; e_fd = 1'b0;
                e_rd = tx_en && (wlog_n != m_ptr[k]) && !wr_en;
            end
            chk($sformatf("tx[%0d]", k),         32'(tx_o[k]),   32'(e_tx));
            chk($sformatf("busy[%0d]", k),       32'(busy_o[k]), 32'(e_busy));
            chk($sformatf("frame_done[%0d]", k), 32'(fd_o[k]),   32'(e_fd));
            chk($sformatf("rd_en[%0d]", k),      32'(rd_o[k]),   32'(e_rd));
            chk($sformatf("fifo_count[%0d]", k), 32'(env_wr - env_rd[k]), 32'(wlog_n - m_ptr[k]));
            if (e_rd) begin
                build_frame(k, wlog[m_ptr[k]]);
                m_ptr[k]++;
            end
        end
        if (wr_en) begin
            wlog[wlog_n] = wr_data;
            wlog_n++;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    function automatic bit all_idle();
        for (int k = 0; k < ND; k++) begin
            if (exp_len[k] != 0 || m_ptr[k] != wlog_n) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic drain(input string tag, input int budget);
        int c;
        c = 0;
        while (!all_idle() && c < budget) begin
            step();
            c++;
        end
        chk({tag, "_drain_in_budget"}, 32'(c < budget), 32'd1);
    endtask

    task automatic push(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        step();
        wr_en   = 1'b0;
    endtask

    initial begin
        int c;
        n_assert = 0;
        n_fail   = 0;
        cyc      = 0;
        wlog_n   = 0;
        for (int k = 0; k < ND; k++) begin
            m_ptr[k]   = 0;
            exp_len[k] = 0;
            exp_pos[k] = 0;
            exp_tx[k]  = '0;
        end
        rst_n   = 1'b1;
        tx_en   = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;

        // Reset held while the FIFO fills with two bytes: no pop allowed.
        tx_en = 1'b1;
        push(8'hA5);
        push(8'h07);
        repeat (3) step();

        // Release: 0xA5 then 0x07 back-to-back on every variant.
        rst_n = 1'b1;
        drain("first_pair", 400);

        // Write stream blocks the pop for three cycles; 0x00 then 0xFF follow.
        tx_en = 1'b0;
        push(8'h3C);
        tx_en   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'h00; step();
        wr_data = 8'hFF; step();
        wr_data = 8'h5A; step();
        wr_en   = 1'b0;
        drain("wr_block", 600);

        // tx_en drops mid-frame: frame finishes, remaining byte stays queued.
        push(8'hC3);
        push(8'h81);
        repeat (10) step();
        tx_en = 1'b0;
        repeat (80) step();
        tx_en = 1'b1;
        drain("tx_en_drop", 400);

        // Randomised traffic.
        for (int it = 0; it < 12; it++) begin
            int nb;
            tx_en = 1'($urandom_range(0, 1));
            nb    = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) begin
                push(8'($urandom));
                repeat ($urandom_range(0, 5)) step();
            end
            repeat ($urandom_range(0, 30)) step();
            tx_en = 1'b1;
            drain("random", 600);
        end

        // Reset during DATA bit 3 of engine 0, then resume with the next byte.
        push(8'($urandom));
        push(8'($urandom));
        c = 0;
        while (!(exp_len[0] != 0 && exp_pos[0] == 19) && c < 200) begin
            step();
            c++;
        end
        chk("abort_reached_bit3", 32'(c < 200), 32'd1);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < ND; k++) begin
            chk($sformatf("abort_tx_immediate[%0d]", k),   32'(tx_o[k]),   32'd1);
            chk($sformatf("abort_busy_immediate[%0d]", k), 32'(busy_o[k]), 32'd0);
        end
        step();
        rst_n = 1'b1;
        drain("after_abort", 400);
        repeat (5) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
